// File: rtl/mips_pkg.sv
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared write-back encodings for the 5-stage MIPS core.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    // Write-back source select; 2'b11 is reserved and treated as the ALU path.
    localparam logic [1:0] MTR_ALU  = 2'b00;
    localparam logic [1:0] MTR_LOAD = 2'b01;
    localparam logic [1:0] MTR_LINK = 2'b10;

    // Load width/extension type; unlisted codes behave as a word load.
    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_HU = 3'b010;
    localparam logic [2:0] LD_B  = 3'b011;
    localparam logic [2:0] LD_BU = 3'b100;

endpackage : mips_pkg

`default_nettype wire

// File: rtl/wb_stage_load_align.sv
// ============================================================================
//  Module      : load_align
//  Description : Little-endian lane select and sign/zero extension of a
//                word-aligned memory read; flags misaligned word/half loads.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
    import mips_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_type,
    output logic [31:0] o_data,
    output logic        o_misalign
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        w_byte = i_word[7:0];
        case (i_off)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
    end

    // The raw flag is qualified by valid/load-select in the enclosing stage.
    always_comb begin
        o_data     = i_word;
        o_misalign = |i_off;
        case (i_type)
            LD_H: begin
                o_data     = {{16{w_half[15]}}, w_half};
                o_misalign = i_off[0];
            end
            LD_HU: begin
                o_data     = {16'h0000, w_half};
                o_misalign = i_off[0];
            end
            LD_B: begin
                o_data     = {{24{w_byte[7]}}, w_byte};
                o_misalign = 1'b0;
            end
            LD_BU: begin
                o_data     = {24'h000000, w_byte};
                o_misalign = 1'b0;
            end
            LD_W: begin
                o_data     = i_word;
                o_misalign = |i_off;
            end
            default: begin
                o_data     = i_word;
                o_misalign = |i_off;
            end
        endcase
    end

endmodule : load_align

`default_nettype wire

// File: rtl/wb_stage.sv
// ============================================================================
//  Module      : wb_stage
//  Description : MEM/WB pipeline register with write-back select, load
//                alignment, register-file write control and retire counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             Flush,
    input  logic             Valid_i,
    input  logic             RegWr_i,
    input  logic [1:0]       MemToReg_i,
    input  logic [2:0]       LoadType_i,
    input  logic [4:0]       Rw_i,
    input  logic [31:0]      ALUResult_i,
    input  logic [31:0]      MemData_i,
    input  logic [31:0]      Link_i,
    output logic             WrEn,
    output logic [4:0]       Rw,
    output logic [31:0]      busW,
    output logic             Misalign,
    output logic [CNT_W-1:0] RetireCnt
);

    logic             r_valid;
    logic             r_regwr;
    logic [1:0]       r_mtr;
    logic [2:0]       r_ldtype;
    logic [4:0]       r_rw;
    logic [31:0]      r_alu;
    logic [31:0]      r_mem;
    logic [31:0]      r_link;
    logic [CNT_W-1:0] r_cnt;

    logic [31:0]      w_load_data;
    logic             w_load_mis;
    logic             w_misalign;

    // A flush only kills the control bits; the data registers may keep
    // stale values because nothing consumes them without valid/regwr.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_valid  <= 1'b0;
            r_regwr  <= 1'b0;
            r_mtr    <= MTR_ALU;
            r_ldtype <= LD_W;
            r_rw     <= 5'd0;
            r_alu    <= 32'd0;
            r_mem    <= 32'd0;
            r_link   <= 32'd0;
            r_cnt    <= '0;
        end else if (Flush) begin
            r_valid  <= 1'b0;
            r_regwr  <= 1'b0;
        end else if (!Stall) begin
            r_valid  <= Valid_i;
            r_regwr  <= RegWr_i;
            r_mtr    <= MemToReg_i;
            r_ldtype <= LoadType_i;
            r_rw     <= Rw_i;
            r_alu    <= ALUResult_i;
            r_mem    <= MemData_i;
            r_link   <= Link_i;
            if (Valid_i) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    load_align u_load_align (
        .i_word     (r_mem),
        .i_off      (r_alu[1:0]),
        .i_type     (r_ldtype),
        .o_data     (w_load_data),
        .o_misalign (w_load_mis)
    );

    assign w_misalign = r_valid & (r_mtr == MTR_LOAD) & w_load_mis;

    always_comb begin
        busW = r_alu;
        case (r_mtr)
            MTR_LOAD: busW = w_load_data;
            MTR_LINK: busW = r_link;
            default:  busW = r_alu;
        endcase
    end

    assign Misalign  = w_misalign;
    assign WrEn      = r_valid & r_regwr & (|r_rw) & ~w_misalign;
    assign Rw        = r_rw;
    assign RetireCnt = r_cnt;

endmodule : wb_stage

`default_nettype wire
